// File: rtl/soc_addr_map_cfg_pkg.sv
// Shared types and constants for the runtime-programmable crossbar address map.
package soc_addr_map_cfg_pkg;

  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned RuleStride = 32;

  typedef struct packed {
    logic [31:0]          idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_t;

  // Per-rule register offsets within one stride.
  localparam logic [4:0] OffStartLo = 5'h00;
  localparam logic [4:0] OffStartHi = 5'h04;
  localparam logic [4:0] OffEndLo   = 5'h08;
  localparam logic [4:0] OffEndHi   = 5'h0c;
  localparam logic [4:0] OffCtrl    = 5'h10;
  localparam logic [4:0] OffIdx     = 5'h14;

  // Global register offsets relative to NumRules * RuleStride.
  localparam int unsigned OffCommit = 0;
  localparam int unsigned OffStatus = 4;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrEmpty   = 2'd1,
    ErrOverlap = 2'd2
  } err_code_e;

  // Builds one reset-image entry from a slave base and window length.
  function automatic rule_t make_rule(input logic [31:0]          idx,
                                      input logic [AddrWidth-1:0] base,
                                      input logic [AddrWidth-1:0] len);
    rule_t r;
    r.idx        = idx;
    r.start_addr = base;
    r.end_addr   = base + len;
    return r;
  endfunction

endpackage

// File: rtl/soc_addr_map_cfg_checker.sv
// Sequential validator: empty-range scan, then pairwise overlap scan, then apply.
module addr_map_checker
  import soc_addr_map_cfg_pkg::*;
#(
  parameter int unsigned NumRules = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  rule_t [NumRules-1:0] rules_i,
  input  logic [NumRules-1:0]  en_i,
  output logic                 busy_o,
  output logic                 apply_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [7:0]           err_i_o,
  output logic [7:0]           err_j_o
);

  localparam int unsigned IdxW = (NumRules > 1) ? $clog2(NumRules) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRules - 1);

  typedef enum logic [1:0] {StIdle, StChkSingle, StChkPair, StApply} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] i_q, i_d, j_q, j_d;
  logic            err_q, err_d;
  err_code_e       code_q, code_d;
  logic [7:0]      erri_q, erri_d, errj_q, errj_d;

  rule_t rule_a, rule_b;
  logic  empty_hit, overlap_hit;

  assign rule_a = rules_i[i_q];
  assign rule_b = rules_i[j_q];
  assign empty_hit = en_i[i_q] && (rule_a.start_addr >= rule_a.end_addr);
  // end_addr is exclusive, so touching ranges do not overlap.
  assign overlap_hit = en_i[i_q] && en_i[j_q] &&
                       (rule_a.start_addr < rule_b.end_addr) &&
                       (rule_b.start_addr < rule_a.end_addr);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    err_d   = err_q;
    code_d  = code_q;
    erri_d  = erri_q;
    errj_d  = errj_q;
    apply_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StChkSingle;
          i_d     = '0;
          j_d     = IdxW'(1);
          err_d   = 1'b0;
          code_d  = ErrNone;
          erri_d  = '0;
          errj_d  = '0;
        end
      end
      StChkSingle: begin
        if (empty_hit) begin
          state_d = StIdle;
          err_d   = 1'b1;
          code_d  = ErrEmpty;
          erri_d  = 8'(i_q);
          errj_d  = '0;
        end else if (i_q == LastIdx) begin
          i_d     = '0;
          j_d     = IdxW'(1);
          state_d = (NumRules > 1) ? StChkPair : StApply;
        end else begin
          i_d = i_q + IdxW'(1);
        end
      end
      StChkPair: begin
        if (overlap_hit) begin
          state_d = StIdle;
          err_d   = 1'b1;
          code_d  = ErrOverlap;
          erri_d  = 8'(i_q);
          errj_d  = 8'(j_q);
        end else if (j_q == LastIdx) begin
          if (i_q == LastIdx - IdxW'(1)) begin
            state_d = StApply;
          end else begin
            i_d = i_q + IdxW'(1);
            j_d = i_q + IdxW'(2);
          end
        end else begin
          j_d = j_q + IdxW'(1);
        end
      end
      StApply: begin
        apply_o = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      erri_q  <= '0;
      errj_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
      code_q  <= code_d;
      erri_q  <= erri_d;
      errj_q  <= errj_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign err_i_o    = erri_q;
  assign err_j_o    = errj_q;

endmodule

// File: rtl/soc_addr_map_cfg.sv
// Register-programmed shadow rule table, validated and atomically copied to the active table.
module soc_addr_map_cfg
  import soc_addr_map_cfg_pkg::*;
#(
  parameter int unsigned          NumRules     = 13,
  parameter int unsigned          RegAddrWidth = 12,
  parameter rule_t [NumRules-1:0] DefaultRules = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    reg_req_i,
  input  logic                    reg_we_i,
  input  logic [RegAddrWidth-1:0] reg_addr_i,
  input  logic [31:0]             reg_wdata_i,
  output logic [31:0]             reg_rdata_o,
  output logic                    reg_ready_o,
  output logic                    reg_error_o,
  output rule_t [NumRules-1:0]    addr_map_o,
  output logic [NumRules-1:0]     rule_en_o,
  output logic                    busy_o,
  output logic                    map_update_o,
  output logic                    cfg_err_o
);

  localparam int unsigned IdxW = (NumRules > 1) ? $clog2(NumRules) : 1;
  localparam logic [RegAddrWidth-1:0] RuleSpan   = RegAddrWidth'(NumRules * RuleStride);
  localparam logic [RegAddrWidth-1:0] AddrCommit = RuleSpan + RegAddrWidth'(OffCommit);
  localparam logic [RegAddrWidth-1:0] AddrStatus = RuleSpan + RegAddrWidth'(OffStatus);

  rule_t [NumRules-1:0] shadow_q, active_q;
  logic  [NumRules-1:0] shadow_en_q, active_en_q;
  logic                 map_update_q;

  logic            busy, apply, chk_err;
  logic [1:0]      err_code;
  logic [7:0]      err_i, err_j;
  logic [IdxW-1:0] sel;
  logic [4:0]      off;
  logic            rule_hit, is_commit, is_status, mapped, stall, wr_en;
  rule_t           cur;
  logic [63:0]     start64, end64;

  assign sel       = IdxW'(reg_addr_i >> 5);
  assign off       = reg_addr_i[4:0];
  assign rule_hit  = (reg_addr_i < RuleSpan) &&
                     (off inside {OffStartLo, OffStartHi, OffEndLo, OffEndHi, OffCtrl, OffIdx});
  assign is_commit = (reg_addr_i == AddrCommit);
  assign is_status = (reg_addr_i == AddrStatus);
  assign mapped    = rule_hit || is_commit || is_status;

  // Table writes are held off while the checker reads the shadow table.
  assign stall       = reg_we_i && busy && (rule_hit || is_commit);
  assign reg_ready_o = rst_ni && reg_req_i && !stall;
  assign reg_error_o = rst_ni && reg_req_i && !mapped;
  assign wr_en       = reg_ready_o && reg_we_i;

  assign cur     = shadow_q[sel];
  assign start64 = 64'(cur.start_addr);
  assign end64   = 64'(cur.end_addr);

  always_comb begin
    reg_rdata_o = '0;
    if (reg_ready_o && mapped) begin
      if (rule_hit) begin
        unique case (off)
          OffStartLo: reg_rdata_o = start64[31:0];
          OffStartHi: reg_rdata_o = start64[63:32];
          OffEndLo:   reg_rdata_o = end64[31:0];
          OffEndHi:   reg_rdata_o = end64[63:32];
          OffCtrl:    reg_rdata_o = {31'b0, shadow_en_q[sel]};
          OffIdx:     reg_rdata_o = cur.idx;
          default:    reg_rdata_o = '0;
        endcase
      end else if (is_status) begin
        reg_rdata_o = {8'b0, err_j, err_i, 4'b0, err_code, chk_err, busy};
      end
    end
  end

  // HI writes are merged through a 64-bit view so bits above AddrWidth drop out.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q    <= DefaultRules;
      shadow_en_q <= '1;
    end else if (wr_en && rule_hit) begin
      unique case (off)
        OffStartLo: shadow_q[sel].start_addr <= AddrWidth'({start64[63:32], reg_wdata_i});
        OffStartHi: shadow_q[sel].start_addr <= AddrWidth'({reg_wdata_i, start64[31:0]});
        OffEndLo:   shadow_q[sel].end_addr   <= AddrWidth'({end64[63:32], reg_wdata_i});
        OffEndHi:   shadow_q[sel].end_addr   <= AddrWidth'({reg_wdata_i, end64[31:0]});
        OffCtrl:    shadow_en_q[sel]         <= reg_wdata_i[0];
        OffIdx:     shadow_q[sel].idx        <= reg_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q     <= DefaultRules;
      active_en_q  <= '1;
      map_update_q <= 1'b0;
    end else begin
      map_update_q <= apply;
      if (apply) begin
        active_q    <= shadow_q;
        active_en_q <= shadow_en_q;
      end
    end
  end

  addr_map_checker #(
    .NumRules(NumRules)
  ) u_checker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (wr_en && is_commit && reg_wdata_i[0]),
    .rules_i   (shadow_q),
    .en_i      (shadow_en_q),
    .busy_o    (busy),
    .apply_o   (apply),
    .err_o     (chk_err),
    .err_code_o(err_code),
    .err_i_o   (err_i),
    .err_j_o   (err_j)
  );

  assign addr_map_o   = active_q;
  assign rule_en_o    = active_en_q;
  assign busy_o       = busy;
  assign map_update_o = map_update_q;
  assign cfg_err_o    = chk_err;

endmodule

// File: tb/tb_soc_addr_map_cfg.sv
// Scoreboarded register-port bench for soc_addr_map_cfg with a realistic reset map.
module tb_soc_addr_map_cfg;
  import soc_addr_map_cfg_pkg::*;

  localparam int unsigned NumR = 13;
  localparam int unsigned RegAw = 12;

  typedef rule_t [NumR-1:0] map_t;

  // Rules 5/6 abut at 0x1C00_0000; others are 1 MiB windows on 16 MiB steps.
  function automatic map_t build_default();
    map_t m;
    for (int n = 0; n < NumR; n++) begin
      if (n == 5)      m[n] = make_rule(32'(n), 64'h1C00_0000, 64'h0010_0000);
      else if (n == 6) m[n] = make_rule(32'(n), 64'h1B00_0000, 64'h0100_0000);
      else             m[n] = make_rule(32'(n), 64'(n) * 64'h0100_0000, 64'h0010_0000);
    end
    return m;
  endfunction

  localparam map_t TbDefault = build_default();

  logic             clk, rst_n, reg_req, reg_we;
  logic [RegAw-1:0] reg_addr;
  logic [31:0]      reg_wdata, reg_rdata;
  logic             reg_ready, reg_error, busy, map_update, cfg_err;
  map_t             addr_map;
  logic [NumR-1:0]  rule_en;

  soc_addr_map_cfg #(
    .NumRules    (NumR),
    .RegAddrWidth(RegAw),
    .DefaultRules(TbDefault)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_req_i   (reg_req),
    .reg_we_i    (reg_we),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .reg_ready_o (reg_ready),
    .reg_error_o (reg_error),
    .addr_map_o  (addr_map),
    .rule_en_o   (rule_en),
    .busy_o      (busy),
    .map_update_o(map_update),
    .cfg_err_o   (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses = 0;
  int   busy_run = 0;
  int   busy_len = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Register-port monitor: pops one expectation per accepted access.
  initial begin : sb_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && reg_req && reg_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: access at %h accepted with no expectation queued", reg_addr);
        end else begin
          e = exp_q.pop_front();
          if (reg_error !== e.err || (e.chk_data && reg_rdata !== e.data)) begin
            n_err++;
            $display("FAIL sb_addr_%h: got data %h err %b expected data %h err %b",
                     reg_addr, reg_rdata, reg_error, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin : evt_monitor
    forever begin
      @(negedge clk);
      if (map_update) pulses++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  // Called at posedge+1; returns at the posedge+1 after acceptance.
  task automatic reg_acc(input logic we, input logic [RegAw-1:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         output int waited, output logic busy_at_acc);
    exp_t e;
    e.data = exp_data;
    e.err = exp_err;
    e.chk_data = !we;
    exp_q.push_back(e);
    reg_req = 1'b1;
    reg_we = we;
    reg_addr = addr;
    reg_wdata = wdata;
    waited = 0;
    busy_at_acc = 1'bx;
    forever begin
      @(negedge clk);
      if (reg_ready) begin
        busy_at_acc = busy;
        break;
      end
      waited++;
      if (waited > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL reg_timeout_%h: no ready after %0d cycles, required ready", addr, waited);
        e = exp_q.pop_back();
        break;
      end
    end
    @(posedge clk);
    #1;
    reg_req = 1'b0;
    reg_we = 1'b0;
  endtask

  task automatic wr(input logic [RegAw-1:0] addr, input logic [31:0] data, input logic err = 1'b0);
    int w;
    logic b;
    reg_acc(1'b1, addr, data, 32'h0, err, w, b);
  endtask

  task automatic rd(input logic [RegAw-1:0] addr, input logic [31:0] exp, input logic err = 1'b0);
    int w;
    logic b;
    reg_acc(1'b0, addr, 32'h0, exp, err, w, b);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int   p0, w;
    logic b;
    rst_n = 1'b0;
    reg_req = 1'b0;
    reg_we = 1'b0;
    reg_addr = '0;
    reg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_map", 64'(addr_map == TbDefault), 64'd1);
    check("rst_en", 64'(rule_en), 64'h1FFF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_update", 64'(map_update), 64'd0);
    rd(12'h1A4, 32'h0);

    // Clean commit moving rule 4, with a status read and a stalled write mid-check.
    wr(12'h080, 32'h1000_0000);
    wr(12'h084, 32'h0);
    wr(12'h088, 32'h1040_0000);
    wr(12'h08C, 32'h0);
    p0 = pulses;
    wr(12'h1A0, 32'h1);
    rd(12'h1A4, 32'h1);
    @(posedge clk);
    #1;
    reg_acc(1'b1, 12'h0F4, 32'h777, 32'h0, 1'b0, w, b);
    check("stall_cycles", 64'(w), 64'd90);
    check("stall_busy_at_accept", 64'(b), 64'd0);
    check("clean_busy_len", 64'(busy_len), 64'd92);
    check("clean_pulses", 64'(pulses - p0), 64'd1);
    check("clean_r4_start", addr_map[4].start_addr, 64'h1000_0000);
    check("clean_r4_end", addr_map[4].end_addr, 64'h1040_0000);
    check("clean_r7_idx_active", 64'(addr_map[7].idx), 64'd7);
    check("clean_cfg_err", 64'(cfg_err), 64'd0);
    rd(12'h0F4, 32'h777);
    rd(12'h1A4, 32'h0);

    // Overlap between rules 5 and 6.
    wr(12'h0C8, 32'h1C00_0100);
    p0 = pulses;
    wr(12'h1A0, 32'h1);
    wait_idle();
    check("ovl_cfg_err", 64'(cfg_err), 64'd1);
    check("ovl_busy_len", 64'(busy_len), 64'd64);
    check("ovl_pulses", 64'(pulses - p0), 64'd0);
    check("ovl_r6_end_active", addr_map[6].end_addr, 64'h1C00_0000);
    rd(12'h1A4, 32'h0006_050A);

    // Empty range on rule 2, then clear its enable.
    wr(12'h0C8, 32'h1C00_0000);
    wr(12'h048, 32'h0200_0000);
    wr(12'h1A0, 32'h1);
    wait_idle();
    check("empty_cfg_err", 64'(cfg_err), 64'd1);
    check("empty_busy_len", 64'(busy_len), 64'd3);
    rd(12'h1A4, 32'h0000_0206);
    wr(12'h050, 32'h0);
    p0 = pulses;
    wr(12'h1A0, 32'h1);
    wait_idle();
    check("dis_cfg_err", 64'(cfg_err), 64'd0);
    check("dis_pulses", 64'(pulses - p0), 64'd1);
    check("dis_busy_len", 64'(busy_len), 64'd92);
    check("dis_en", 64'(rule_en), 64'h1FFB);
    check("dis_r2_end", addr_map[2].end_addr, 64'h0200_0000);
    check("dis_r6_end", addr_map[6].end_addr, 64'h1C00_0000);
    rd(12'h1A4, 32'h0);
    rd(12'h050, 32'h0);
    rd(12'h070, 32'h1);

    // Reset forty cycles into a check.
    p0 = pulses;
    wr(12'h1A0, 32'h1);
    repeat (39) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_map", 64'(addr_map == TbDefault), 64'd1);
    check("mid_en", 64'(rule_en), 64'h1FFF);
    check("mid_cfg_err", 64'(cfg_err), 64'd0);
    repeat (120) @(posedge clk);
    #1;
    check("mid_pulses", 64'(pulses - p0), 64'd0);
    check("mid_map_late", 64'(addr_map == TbDefault), 64'd1);
    rd(12'h080, 32'h0400_0000);

    // Unmapped holes and other decode edges.
    wr(12'h018, 32'hFFFF_FFFF, 1'b1);
    rd(12'h018, 32'h0, 1'b1);
    rd(12'h01C, 32'h0, 1'b1);
    rd(12'h1A8, 32'h0, 1'b1);
    rd(12'h000, 32'h0);
    rd(12'h008, 32'h0010_0000);
    rd(12'h014, 32'h0);
    rd(12'h010, 32'h1);
    rd(12'h1A0, 32'h0);
    check("unm_map", 64'(addr_map == TbDefault), 64'd1);
    check("unm_busy", 64'(busy), 64'd0);

    @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
